// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions for the issue-side hazard logic: stall FSM states,
// register-index type and the operand dependency compare.
package cpu_pipe_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        MC_BUSY = 1'b1
    } state_e;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t    REG_ZERO       = 5'd0;
    localparam int unsigned MC_LATENCY_DEF = 4;

    // x0 is hard-wired zero, so a write to it can never create a true dependency.
    function automatic logic reads_reg(input reg_idx_t rs1, input reg_idx_t rs2,
                                       input logic use_rs2, input reg_idx_t rd);
        return (rd != REG_ZERO) && ((rs1 == rd) || (use_rs2 && (rs2 == rd)));
    endfunction

endpackage

// File: rtl/mc_busy_counter.sv
// Loadable down-counter timing the EX freeze of a multi-cycle op; stops at zero.
module mc_busy_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             done_o,
    output logic             busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));
    assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// IF/ID hazard stall control: load-use bubbles and multi-cycle EX freeze.
// Define HAZARD_STALL_STATS_EN to add saturating stall-cycle counters.
module hazard_stall_unit
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned MC_LATENCY = MC_LATENCY_DEF,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  IDrs1_i,
    input  logic [4:0]  IDrs2_i,
    input  logic        IDUseRs2_i,
    input  logic        EXMemRead_i,
    input  logic [4:0]  EXrd_i,
    input  logic        EXMultiCycle_i,
    input  logic        Flush_i,
    output logic        PCWrite_o,
    output logic        IFIDWrite_o,
    output logic        NoOp_o,
    output logic        EXStall_o,
    output logic        Busy_o
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0] LoadStallCnt_o,
    output logic [31:0] MCStallCnt_o
`endif
);

    if ((MC_LATENCY < 2) || (MC_LATENCY > 15) || ((MC_LATENCY - 1) >= (1 << CNT_W))) begin : g_param_check
        $error("hazard_stall_unit: MC_LATENCY out of range or does not fit in CNT_W");
    end

    state_e   state_q, state_d;
    reg_idx_t pend_rd_q, pend_rd_d;
    logic     dep_ex, load_stall, mc_enter, cnt_done, cnt_busy;

    assign dep_ex = reads_reg(IDrs1_i, IDrs2_i, IDUseRs2_i, EXrd_i);

    always_comb begin
        state_d     = state_q;
        pend_rd_d   = pend_rd_q;
        load_stall  = 1'b0;
        mc_enter    = 1'b0;
        PCWrite_o   = 1'b1;
        IFIDWrite_o = 1'b1;
        NoOp_o      = 1'b0;
        EXStall_o   = 1'b0;
        Busy_o      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A taken branch redirect wins over a load-use bubble; a load
                // flagged multi-cycle is handled purely as a load.
                load_stall = EXMemRead_i && dep_ex && !Flush_i;
                mc_enter   = EXMultiCycle_i && !EXMemRead_i;
                if (load_stall) begin
                    PCWrite_o   = 1'b0;
                    IFIDWrite_o = 1'b0;
                    NoOp_o      = 1'b1;
                end
                if (mc_enter) begin
                    PCWrite_o   = 1'b0;
                    IFIDWrite_o = 1'b0;
                    EXStall_o   = 1'b1;
                    pend_rd_d   = EXrd_i;
                    state_d     = MC_BUSY;
                end
            end
            MC_BUSY: begin
                PCWrite_o   = 1'b0;
                IFIDWrite_o = 1'b0;
                EXStall_o   = 1'b1;
                Busy_o      = 1'b1;
                if (cnt_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            pend_rd_q <= REG_ZERO;
        end else begin
            state_q   <= state_d;
            pend_rd_q <= pend_rd_d;
        end
    end

    mc_busy_counter #(
        .CNT_W (CNT_W)
    ) u_mc_busy_counter (
        .clk_i      (clk_i),
        .rst_ni     (rst_i),
        .load_i     (mc_enter),
        .load_val_i (CNT_W'(MC_LATENCY - 1)),
        .done_o     (cnt_done),
        .busy_o     (cnt_busy)
    );

    // EX is frozen while busy, so its destination must stay the one latched at issue.
    busy_consistent_a : assert property (@(posedge clk_i) disable iff (!rst_i)
        (state_q == MC_BUSY) |-> (cnt_busy && (EXrd_i == pend_rd_q)));

`ifdef HAZARD_STALL_STATS_EN
    logic [31:0] ls_cnt_q, ls_cnt_d, mc_cnt_q, mc_cnt_d;

    always_comb begin
        ls_cnt_d = ls_cnt_q;
        mc_cnt_d = mc_cnt_q;
        if (load_stall && (ls_cnt_q != '1)) begin
            ls_cnt_d = ls_cnt_q + 32'd1;
        end
        if (EXStall_o && (mc_cnt_q != '1)) begin
            mc_cnt_d = mc_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ls_cnt_q <= '0;
            mc_cnt_q <= '0;
        end else begin
            ls_cnt_q <= ls_cnt_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign LoadStallCnt_o = ls_cnt_q;
    assign MCStallCnt_o   = mc_cnt_q;
`endif

endmodule
